// File: rtl/pdp_pkg.sv
// Shared PDP-8 definitions for the effective-address fetch unit:
// field positions, auto-index window, opcode and FSM state encodings.
package pdp_pkg;

    localparam int ADDR_WIDTH = 12;
    localparam int DATA_WIDTH = 12;

    localparam logic [ADDR_WIDTH-1:0] AUTO_LO = 12'o0010;
    localparam logic [ADDR_WIDTH-1:0] AUTO_HI = 12'o0017;

    localparam int OPC_MSB  = 11;
    localparam int OPC_LSB  = 9;
    localparam int IND_BIT  = 8;
    localparam int PAGE_BIT = 7;
    localparam int OFF_MSB  = 6;
    localparam int OFF_LSB  = 0;

    typedef enum logic [2:0] {
        OP_AND = 3'd0,
        OP_TAD = 3'd1,
        OP_ISZ = 3'd2,
        OP_DCA = 3'd3,
        OP_JMS = 3'd4,
        OP_JMP = 3'd5,
        OP_IOT = 3'd6,
        OP_OPR = 3'd7
    } opcode_t;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_IND_RD   = 3'd1,
        ST_IND_WAIT = 3'd2,
        ST_AUTO_WR  = 3'd3,
        ST_OP_RD    = 3'd4,
        ST_OP_WAIT  = 3'd5,
        ST_DONE     = 3'd6
    } ea_state_t;

    function automatic logic opcode_fetches(input opcode_t op);
        return (op == OP_AND) || (op == OP_TAD) || (op == OP_ISZ);
    endfunction

endpackage

// File: rtl/pdp_ea_calc.sv
// Combinational decode of a PDP-8 memory-reference instruction:
// direct EA, auto-index window hit, indirect and operand-fetch flags.
module pdp_ea_calc #(
    parameter int ADDR_W = pdp_pkg::ADDR_WIDTH,
    parameter int DATA_W = pdp_pkg::DATA_WIDTH,
    parameter logic [ADDR_W-1:0] AUTO_LO = pdp_pkg::AUTO_LO,
    parameter logic [ADDR_W-1:0] AUTO_HI = pdp_pkg::AUTO_HI
) (
    input  logic [DATA_W-1:0] instr,
    input  logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] direct_ea,
    output logic              indirect,
    output logic              needs_fetch,
    output logic              no_access,
    output logic              in_auto
);
    import pdp_pkg::*;

    opcode_t opc_s;
    logic    unused_pc_s;

    assign opc_s       = opcode_t'(instr[OPC_MSB:OPC_LSB]);
    // Only the page bits of the PC take part in current-page addressing.
    assign unused_pc_s = ^pc[OFF_MSB:OFF_LSB];

    // Page-zero or current-page address plus the access-class flags.
    always_comb begin
        if (instr[PAGE_BIT]) begin
            direct_ea = {pc[ADDR_W-1:OFF_MSB+1], instr[OFF_MSB:OFF_LSB]};
        end else begin
            direct_ea = {{(ADDR_W-OFF_MSB-1){1'b0}}, instr[OFF_MSB:OFF_LSB]};
        end
        no_access   = (opc_s == OP_IOT) || (opc_s == OP_OPR);
        indirect    = instr[IND_BIT] && !no_access;
        needs_fetch = opcode_fetches(opc_s);
        in_auto     = (direct_ea >= AUTO_LO) && (direct_ea <= AUTO_HI);
    end

endmodule

// File: rtl/pdp_ea_fetch.sv
// Effective-address resolver and operand fetcher driving the exec
// read/write ports of memory_pdp; reports EA and operand with a done pulse.
module pdp_ea_fetch #(
    parameter int ADDR_W = pdp_pkg::ADDR_WIDTH,
    parameter int DATA_W = pdp_pkg::DATA_WIDTH,
    parameter logic [ADDR_W-1:0] AUTO_LO = pdp_pkg::AUTO_LO,
    parameter logic [ADDR_W-1:0] AUTO_HI = pdp_pkg::AUTO_HI
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [DATA_W-1:0] instr,
    input  logic [ADDR_W-1:0] pc,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] ea,
    output logic [DATA_W-1:0] operand,
    output logic              exec_rd_req,
    output logic [ADDR_W-1:0] exec_rd_addr,
    input  logic [DATA_W-1:0] exec_rd_data,
    output logic              exec_wr_req,
    output logic [ADDR_W-1:0] exec_wr_addr,
    output logic [DATA_W-1:0] exec_wr_data
);
    import pdp_pkg::*;

    localparam logic [DATA_W-1:0] ONE_D = {{(DATA_W-1){1'b0}}, 1'b1};

    ea_state_t         state_q, state_d;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] ea_q, ea_d;
    logic [DATA_W-1:0] operand_q, operand_d;
    logic [DATA_W-1:0] ptr_q, ptr_d;

    logic [DATA_W-1:0] calc_instr_s;
    logic [ADDR_W-1:0] calc_pc_s;
    logic [ADDR_W-1:0] direct_ea_s;
    logic              indirect_s, needs_fetch_s, no_access_s, in_auto_s;

    // Decode the live inputs while idle, the captured instruction otherwise.
    always_comb begin
        if (state_q == ST_IDLE) begin
            calc_instr_s = instr;
            calc_pc_s    = pc;
        end else begin
            calc_instr_s = instr_q;
            calc_pc_s    = pc_q;
        end
    end

    pdp_ea_calc #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .AUTO_LO(AUTO_LO),
        .AUTO_HI(AUTO_HI)
    ) u_calc (
        .instr      (calc_instr_s),
        .pc         (calc_pc_s),
        .direct_ea  (direct_ea_s),
        .indirect   (indirect_s),
        .needs_fetch(needs_fetch_s),
        .no_access  (no_access_s),
        .in_auto    (in_auto_s)
    );

    // Next-state and datapath updates of the resolution sequence.
    always_comb begin
        state_d   = state_q;
        instr_d   = instr_q;
        pc_d      = pc_q;
        ea_d      = ea_q;
        operand_d = operand_q;
        ptr_d     = ptr_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    instr_d   = instr;
                    pc_d      = pc;
                    operand_d = '0;
                    ea_d      = no_access_s ? '0 : direct_ea_s;
                    if (no_access_s) begin
                        state_d = ST_DONE;
                    end else if (indirect_s) begin
                        state_d = ST_IND_RD;
                    end else if (needs_fetch_s) begin
                        state_d = ST_OP_RD;
                    end else begin
                        state_d = ST_DONE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_IND_RD:   state_d = ST_IND_WAIT;
            ST_IND_WAIT: begin
                ptr_d = exec_rd_data;
                // Auto-index pointers are pre-incremented with 12-bit wrap.
                if (in_auto_s) begin
                    ea_d    = ADDR_W'(exec_rd_data + ONE_D);
                    state_d = ST_AUTO_WR;
                end else begin
                    ea_d    = ADDR_W'(exec_rd_data);
                    state_d = needs_fetch_s ? ST_OP_RD : ST_DONE;
                end
            end
            ST_AUTO_WR:  state_d = needs_fetch_s ? ST_OP_RD : ST_DONE;
            ST_OP_RD:    state_d = ST_OP_WAIT;
            ST_OP_WAIT: begin
                operand_d = exec_rd_data;
                state_d   = ST_DONE;
            end
            ST_DONE:     state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            instr_q   <= '0;
            pc_q      <= '0;
            ea_q      <= '0;
            operand_q <= '0;
            ptr_q     <= '0;
        end else begin
            state_q   <= state_d;
            instr_q   <= instr_d;
            pc_q      <= pc_d;
            ea_q      <= ea_d;
            operand_q <= operand_d;
            ptr_q     <= ptr_d;
        end
    end

    // Memory requests depend on the state register and captured values only.
    always_comb begin
        exec_rd_req  = 1'b0;
        exec_rd_addr = '0;
        exec_wr_req  = 1'b0;
        exec_wr_addr = '0;
        exec_wr_data = '0;
        case (state_q)
            ST_IND_RD: begin
                exec_rd_req  = 1'b1;
                exec_rd_addr = direct_ea_s;
            end
            ST_OP_RD: begin
                exec_rd_req  = 1'b1;
                exec_rd_addr = ea_q;
            end
            ST_AUTO_WR: begin
                exec_wr_req  = 1'b1;
                exec_wr_addr = direct_ea_s;
                exec_wr_data = ptr_q + ONE_D;
            end
            default: begin
                exec_rd_req = 1'b0;
            end
        endcase
    end

    assign busy    = (state_q != ST_IDLE);
    assign done    = (state_q == ST_DONE);
    assign ea      = ea_q;
    assign operand = operand_q;

endmodule

// File: tb/tb_pdp_ea_fetch.sv
// Randomized self-checking bench for pdp_ea_fetch with a behavioural
// memory and a high-level PDP-8 addressing reference model.
module tb_pdp_ea_fetch;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [11:0] instr = 12'd0;
    logic [11:0] pc = 12'd0;
    logic        busy, done;
    logic [11:0] ea, operand;
    logic        exec_rd_req, exec_wr_req;
    logic [11:0] exec_rd_addr, exec_wr_addr, exec_wr_data;
    logic [11:0] exec_rd_data = 12'd0;

    always #5 clk = ~clk;

    pdp_ea_fetch dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .instr       (instr),
        .pc          (pc),
        .busy        (busy),
        .done        (done),
        .ea          (ea),
        .operand     (operand),
        .exec_rd_req (exec_rd_req),
        .exec_rd_addr(exec_rd_addr),
        .exec_rd_data(exec_rd_data),
        .exec_wr_req (exec_wr_req),
        .exec_wr_addr(exec_wr_addr),
        .exec_wr_data(exec_wr_data)
    );

    // Memory model: DUT writes commit at the sampling edge, read data follows one cycle later.
    logic [11:0] mem [4096];
    logic        init_req = 1'b0;
    logic        bd_en = 1'b0;
    logic [11:0] bd_addr = 12'd0;
    logic [11:0] bd_data = 12'd0;
    logic [11:0] rd_log [$];
    int          wr_cnt = 0;
    int          prot_err = 0;

    always @(posedge clk) begin
        if (init_req) begin
            for (int k = 0; k < 4096; k++) mem[k] <= 12'(k);
        end else if (bd_en) begin
            mem[bd_addr] <= bd_data;
        end
        if (exec_wr_req) begin
            mem[exec_wr_addr] <= exec_wr_data;
            wr_cnt <= wr_cnt + 1;
        end
        exec_rd_data <= exec_rd_req ? mem[exec_rd_addr] : 12'd0;
        if (exec_rd_req) rd_log.push_back(exec_rd_addr);
        if ((exec_rd_req && exec_wr_req) ||
            (!exec_rd_req && exec_rd_addr != 12'd0) ||
            (!exec_wr_req && (exec_wr_addr != 12'd0 || exec_wr_data != 12'd0)))
            prot_err <= prot_err + 1;
    end

    int          n_cmp = 0;
    int          n_fail = 0;
    logic [11:0] ref_mem [4096];
    logic [11:0] exp_ea, exp_op, exp_wa, exp_wd;
    logic [11:0] exp_rd [$];
    int          exp_lat, exp_wr;

    // Reference: PDP-8 addressing rules expressed with plain arithmetic.
    task automatic model(input logic [11:0] i, input logic [11:0] p);
        int opc, page_base, d, eff, t;
        opc = int'(i[11:9]);
        exp_rd.delete();
        exp_wr  = 0;
        exp_op  = 12'd0;
        exp_lat = 1;
        exp_wa  = 12'd0;
        exp_wd  = 12'd0;
        if (opc >= 6) begin
            exp_ea = 12'd0;
        end else begin
            page_base = i[7] ? (int'(p) / 128) * 128 : 0;
            d   = page_base + int'(i) % 128;
            eff = d;
            if (i[8]) begin
                exp_rd.push_back(12'(d));
                exp_lat += 2;
                eff = int'(ref_mem[d]);
                if (d >= 8 && d <= 15) begin
                    t = (eff + 1) % 4096;
                    ref_mem[d] = 12'(t);
                    exp_wr  = 1;
                    exp_wa  = 12'(d);
                    exp_wd  = 12'(t);
                    exp_lat += 1;
                    eff = t;
                end
            end
            exp_ea = 12'(eff);
            if (opc < 3) begin
                exp_rd.push_back(12'(eff));
                exp_op  = ref_mem[eff];
                exp_lat += 2;
            end
        end
    endtask

    task automatic mem_init();
        for (int k = 0; k < 4096; k++) ref_mem[k] = 12'(k);
        @(negedge clk); init_req = 1'b1;
        @(negedge clk); init_req = 1'b0;
    endtask

    task automatic poke(input logic [11:0] a, input logic [11:0] d);
        ref_mem[a] = d;
        @(negedge clk); bd_en = 1'b1; bd_addr = a; bd_data = d;
        @(negedge clk); bd_en = 1'b0;
    endtask

    task automatic do_op(input logic [11:0] i, input logic [11:0] p, input bit repulse);
        int rd0, wr0, pe0, cyc, nrd;
        bit got;
        model(i, p);
        @(negedge clk);
        rd0 = rd_log.size(); wr0 = wr_cnt; pe0 = prot_err;
        instr = i; pc = p; start = 1'b1;
        @(negedge clk);
        start = 1'b0; instr = 12'($urandom); pc = 12'($urandom);
        cyc = 1; got = 1'b0;
        while (!got && cyc <= 20) begin
            if (done === 1'b1) begin
                got = 1'b1;
            end else begin
                if (cyc == 1) begin
                    n_cmp++;
                    if (busy !== 1'b1) begin
                        n_fail++; $display("FAIL busy_mid %o: got %b want 1", i, busy);
                    end
                end
                start = (repulse && cyc == 2);
                if (start) instr = 12'($urandom);
                @(negedge clk);
                cyc++;
            end
        end
        start = 1'b0;
        n_cmp++;
        if (!got || cyc != exp_lat) begin
            n_fail++; $display("FAIL latency %o: got %0d want %0d (done seen %b)", i, cyc, exp_lat, got);
        end
        n_cmp++;
        if (ea !== exp_ea) begin
            n_fail++; $display("FAIL ea %o pc %o: got %o want %o", i, p, ea, exp_ea);
        end
        n_cmp++;
        if (operand !== exp_op) begin
            n_fail++; $display("FAIL operand %o: got %o want %o", i, operand, exp_op);
        end
        nrd = rd_log.size() - rd0;
        n_cmp++;
        if (nrd != exp_rd.size()) begin
            n_fail++; $display("FAIL read_count %o: got %0d want %0d", i, nrd, exp_rd.size());
        end else begin
            for (int j = 0; j < nrd; j++) begin
                n_cmp++;
                if (rd_log[rd0 + j] !== exp_rd[j]) begin
                    n_fail++; $display("FAIL read_addr %o #%0d: got %o want %o", i, j, rd_log[rd0 + j], exp_rd[j]);
                end
            end
        end
        n_cmp++;
        if (wr_cnt - wr0 != exp_wr) begin
            n_fail++; $display("FAIL write_count %o: got %0d want %0d", i, wr_cnt - wr0, exp_wr);
        end
        if (exp_wr == 1) begin
            n_cmp++;
            if (mem[exp_wa] !== exp_wd) begin
                n_fail++; $display("FAIL auto_write %o at %o: got %o want %o", i, exp_wa, mem[exp_wa], exp_wd);
            end
        end
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL after_done %o: done %b busy %b want 0 0", i, done, busy);
        end
        n_cmp++;
        if (prot_err != pe0) begin
            n_fail++; $display("FAIL protocol %o: got %0d violations want 0", i, prot_err - pe0);
        end
    endtask

    task automatic test_reset();
        int rd0;
        #1;
        n_cmp++;
        if ({busy, done, ea, operand, exec_rd_req, exec_rd_addr, exec_wr_req, exec_wr_addr, exec_wr_data} !== 64'd0) begin
            n_fail++; $display("FAIL reset_outputs: got busy %b done %b ea %o op %o want all 0", busy, done, ea, operand);
        end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        mem_init();
        poke(12'o0045, 12'o3000);
        @(negedge clk); instr = 12'o1445; pc = 12'o0200; start = 1'b1;
        @(negedge clk); start = 1'b0;
        n_cmp++;
        if (exec_rd_req !== 1'b1) begin
            n_fail++; $display("FAIL reset_setup: rd_req got %b want 1", exec_rd_req);
        end
        #2 reset_n = 1'b0;
        #1;
        n_cmp++;
        if ({busy, done, ea, operand, exec_rd_req, exec_rd_addr, exec_wr_req, exec_wr_addr, exec_wr_data} !== 64'd0) begin
            n_fail++; $display("FAIL reset_abort: got busy %b done %b rd %b ea %o want all 0", busy, done, exec_rd_req, ea);
        end
        rd0 = rd_log.size();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            n_cmp++;
            if (busy !== 1'b0 || done !== 1'b0 || exec_rd_req !== 1'b0 || exec_wr_req !== 1'b0) begin
                n_fail++; $display("FAIL reset_idle c%0d: busy %b done %b rd %b wr %b want 0", c, busy, done, exec_rd_req, exec_wr_req);
            end
        end
        n_cmp++;
        if (rd_log.size() != rd0) begin
            n_fail++; $display("FAIL reset_reads: got %0d extra want 0", rd_log.size() - rd0);
        end
    endtask

    task automatic test_directed();
        mem_init();
        do_op(12'o1045, 12'o0200, 1'b0);
        do_op(12'o0245, 12'o2300, 1'b0);
        poke(12'o0045, 12'o3000);
        poke(12'o3000, 12'o1234);
        poke(12'o0010, 12'o0777);
        poke(12'o0017, 12'o7777);
        do_op(12'o1445, 12'o0200, 1'b0);
        do_op(12'o5445, 12'o0200, 1'b0);
        do_op(12'o1410, 12'o0200, 1'b0);
        do_op(12'o2417, 12'o0200, 1'b0);
        do_op(12'o3045, 12'o4000, 1'b0);
    endtask

    task automatic test_no_access();
        do_op(12'o7200, 12'o0200, 1'b0);
        do_op(12'o6031, 12'o1234, 1'b0);
    endtask

    task automatic test_busy_ignore();
        do_op(12'o1445, 12'o0200, 1'b1);
        do_op(12'o0411, 12'o5000, 1'b1);
    endtask

    task automatic test_random();
        logic [11:0] i;
        for (int n = 0; n < 250; n++) begin
            if ($urandom_range(0, 2) == 0)
                poke($urandom_range(0, 1) ? 12'($urandom_range(0, 127)) : 12'($urandom), 12'($urandom));
            i = 12'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                i[7]   = 1'b0;
                i[6:0] = 7'($urandom_range(8, 15));
            end
            do_op(i, 12'($urandom), ($urandom_range(0, 3) == 0));
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_no_access();
        test_busy_ignore();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/pdp_ea_fetch.md
Name: pdp_ea_fetch

Overview:
Execution-unit initiator for the exec read/write ports of memory_pdp. Given a PDP-8 instruction word and PC, it resolves the effective address (EA), handling page-zero, current-page, indirect and auto-index addressing. It then fetches the operand for AND/TAD/ISZ and returns EA plus operand to the execute sequencer with a one-cycle done pulse.

Parameters:
ADDR_W, 12, memory address width (matches `ADDR_WIDTH)
DATA_W, 12, memory word width (matches `DATA_WIDTH)
AUTO_LO, 12'o0010, first auto-index location
AUTO_HI, 12'o0017, last auto-index location

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
start  in  1  pulse: begin resolution of instr/pc (sampled only in IDLE)
instr  in  12  instruction word; [11:9] opcode, [8] I, [7] P, [6:0] offset
pc  in  12  address of the current instruction
busy  out  1  high from the cycle after start is accepted until done
done  out  1  one-cycle pulse; ea/operand valid from this cycle
ea  out  12  resolved effective address (held until the next accepted start)
operand  out  12  fetched operand (0 when not fetched)
exec_rd_req  out  1  memory read request
exec_rd_addr  out  12  memory read address
exec_rd_data  in  12  memory read data, valid the cycle after req is sampled
exec_wr_req  out  1  memory write request
exec_wr_addr  out  12  memory write address
exec_wr_data  out  12  memory write data

Behaviour:
- Reset (async, reset_n=0): state=IDLE; all outputs and internal registers are 0. Reset mid-operation aborts with no further requests.
- Memory protocol: the memory samples req/addr at a posedge. Read data is valid in the following cycle. A write commits at the sampling edge.
- Request outputs are decoded from the state register only; there is no combinational path from inputs.
- Direct EA: P=0 gives {5'b0, offset}. P=1 gives {pc[11:7], offset}.
- Operand fetch only for opcodes 0, 1, 2 (AND, TAD, ISZ). Opcodes 3, 4, 5 (DCA, JMS, JMP) resolve EA only. Opcodes 6, 7 (IOT, OPR) make no memory access: ea=0, operand=0.
- States and transitions:
  - IDLE -> DONE when start and no memory access is needed.
  - IDLE -> IND_RD when start and I=1 and opcode<6.
  - IDLE -> OP_RD when start, I=0 and a fetch is needed.
  - IND_RD: exec_rd_req=1, rd_addr=direct EA. -> IND_WAIT.
  - IND_WAIT: capture ptr=exec_rd_data. If direct EA is in AUTO_LO..AUTO_HI -> AUTO_WR. Else EA=ptr, then -> OP_RD if a fetch is needed, else -> DONE.
  - AUTO_WR: exec_wr_req=1, wr_addr=direct EA, wr_data=(ptr+1) mod 4096, EA=ptr+1. Then -> OP_RD if a fetch is needed, else -> DONE.
  - OP_RD: exec_rd_req=1, rd_addr=EA. -> OP_WAIT.
  - OP_WAIT: capture operand. -> DONE.
  - DONE: done=1 for one cycle. -> IDLE.
- Latency (start-sampling edge to done-high cycle):
  - no access or direct with no fetch: 1
  - direct fetch: 3
  - indirect with no fetch: 3
  - indirect fetch: 5
  - auto-index adds 1
- Arithmetic: auto-index increment is 12-bit wrap (7777 -> 0000), with no carry out.
- start while busy is ignored, and instr/pc are not re-sampled. instr and pc are registered at acceptance, so the caller may change them afterwards.
- Only one of exec_rd_req and exec_wr_req is high in any cycle. Addresses and data are 0 when the matching req is low.

Decomposition:
- Shared package pdp_pkg: opcode enum (AND, TAD, ISZ, DCA, JMS, JMP, IOT, OPR), field bit positions, AUTO_LO/AUTO_HI, and the state enum typedef ea_state_t.
- One sub-module, pdp_ea_calc: combinational direct-EA, auto-index-range and needs-fetch decode. The FSM stays in the top.

Test Plan:
- Reset: hold reset_n=0 mid-indirect sequence -> all outputs 0 immediately; state IDLE after release; no req pulses.
- Page-zero TAD: instr=1045, pc=0200 (memory preloaded mem[k]=k) -> one read of 0045; done at cycle 3; ea=0045, operand=0045.
- Current-page AND: instr=0245, pc=2300 -> read 2245; ea=2245, operand=2245.
- Indirect TAD: mem[0045]=3000, mem[3000]=1234, instr=1445 -> reads 0045 then 3000; done at cycle 5; ea=3000, operand=1234. JMP I 5445 -> only read 0045; done at cycle 3; operand=0.
- Auto-index: mem[0010]=0777, instr=1410 -> write 1000 to 0010, then read 1000; ea=1000; done at cycle 6. Wrap case: mem[0017]=7777, instr=2417 -> write 0000 to 0017; ea=0000.
- Busy/no-access: OPR 7200 -> done at cycle 1 with no req. start re-pulsed during an indirect fetch -> ignored, first result unchanged.
